// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync FIFO controller and memory.
package sync_fifo_pkg;

    // Default geometry of the PE-array FIFOs.
    localparam int unsigned DefRDataWidth = 64;
    localparam int unsigned DefWDataWidth = 16;
    localparam int unsigned DefMemWidth   = 16;
    localparam int unsigned DefFifoDepth  = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Memory words per port beat.
    function automatic int unsigned words(input int unsigned data_w, input int unsigned mem_w);
        return data_w / mem_w;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Word counts of the default configuration.
    localparam int unsigned W_WORDS = words(DefWDataWidth, DefMemWidth);
    localparam int unsigned R_WORDS = words(DefRDataWidth, DefMemWidth);

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer and occupancy controller for sync_fifo_mem. Occupancy is kept in memory words so
// asymmetric write/read widths produce correct full/empty flags. No data passes through here.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned R_DATA_WIDTH = 64,
    parameter int unsigned W_DATA_WIDTH = 16,
    parameter int unsigned MEM_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned WWords = words(W_DATA_WIDTH, MEM_WIDTH);
    localparam int unsigned RWords = words(R_DATA_WIDTH, MEM_WIDTH);

    // Elaboration-time geometry checks.
    if ((W_DATA_WIDTH % MEM_WIDTH) != 0) begin : g_bad_w_width
        $error("W_DATA_WIDTH must be a multiple of MEM_WIDTH");
    end
    if ((R_DATA_WIDTH % MEM_WIDTH) != 0) begin : g_bad_r_width
        $error("R_DATA_WIDTH must be a multiple of MEM_WIDTH");
    end
    if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two");
    end
    if ((FIFO_DEPTH % WWords) != 0 || (FIFO_DEPTH % RWords) != 0) begin : g_bad_align
        $error("FIFO_DEPTH must be a multiple of both beat word counts");
    end
    if (ADDR_WIDTH != clog2(FIFO_DEPTH)) begin : g_bad_addr
        $error("ADDR_WIDTH must equal log2(FIFO_DEPTH)");
    end

    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [ADDR_WIDTH+1:0] count_ext;
    logic                  unused_count_msb;

    // Flags and enables derive from registered count, so a push is never poppable same-cycle.
    always_comb begin
        full  = count_q > (ADDR_WIDTH + 1)'(FIFO_DEPTH - WWords);
        empty = count_q < (ADDR_WIDTH + 1)'(RWords);
        wr_en = push & ~full & ~reset;
        rd_en = pop & ~empty & ~reset;
    end

    // Next-state: pointers advance by one beat per accepted request, wrapping naturally.
    always_comb begin
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
        if (wr_en) wr_addr_d = wr_addr_q + ADDR_WIDTH'(WWords);
        if (rd_en) rd_addr_d = rd_addr_q + ADDR_WIDTH'(RWords);
        // Extra headroom bit keeps the intermediate sum exact; the result fits 0..FIFO_DEPTH.
        count_ext = {1'b0, count_q}
                  + (wr_en ? (ADDR_WIDTH + 2)'(WWords) : '0)
                  - (rd_en ? (ADDR_WIDTH + 2)'(RWords) : '0);
        count_d          = count_ext[ADDR_WIDTH:0];
        unused_count_msb = count_ext[ADDR_WIDTH+1];
    end

    // State registers with synchronous reset; the memory array is not cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: default (16 in / 64 out) and swapped (64 in / 16 out)
// instances, each paired with a small behavioural memory to check addressing end to end.
module tb_sync_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic push_a, pop_a, push_b, pop_b;
    logic wr_en_a, rd_en_a, full_a, empty_a, ovf_a, unf_a;
    logic wr_en_b, rd_en_b, full_b, empty_b, ovf_b, unf_b;
    logic [3:0] wr_addr_a, rd_addr_a, wr_addr_b, rd_addr_b;
    logic [4:0] count_a, count_b;
    logic [15:0] wdata_a;
    logic [63:0] wdata_b;
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    logic [63:0] rdata_a;
    logic [15:0] rdata_b;

    int n_checks = 0;
    int n_fails  = 0;

    sync_fifo_ctrl #(
        .R_DATA_WIDTH(64), .W_DATA_WIDTH(16), .MEM_WIDTH(16), .FIFO_DEPTH(16), .ADDR_WIDTH(4)
    ) u_dut_a (
        .clk(clk), .reset(reset), .push(push_a), .pop(pop_a),
        .wr_en(wr_en_a), .rd_en(rd_en_a), .wr_addr(wr_addr_a), .rd_addr(rd_addr_a),
        .full(full_a), .empty(empty_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo_ctrl #(
        .R_DATA_WIDTH(16), .W_DATA_WIDTH(64), .MEM_WIDTH(16), .FIFO_DEPTH(16), .ADDR_WIDTH(4)
    ) u_dut_b (
        .clk(clk), .reset(reset), .push(push_b), .pop(pop_b),
        .wr_en(wr_en_b), .rd_en(rd_en_b), .wr_addr(wr_addr_b), .rd_addr(rd_addr_b),
        .full(full_b), .empty(empty_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    // Behavioural memories: negedge write, combinational show-ahead read.
    always @(negedge clk) begin
        if (wr_en_a) mem_a[wr_addr_a] <= wdata_a;
        if (wr_en_b) begin
            for (int k = 0; k < 4; k++) mem_b[(int'(wr_addr_b) + k) % 16] <= wdata_b[16*k +: 16];
        end
    end

    assign rdata_a = {mem_a[rd_addr_a + 4'd3], mem_a[rd_addr_a + 4'd2],
                      mem_a[rd_addr_a + 4'd1], mem_a[rd_addr_a]};
    assign rdata_b = mem_b[rd_addr_b];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next posedge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    logic [63:0] exp_beat;

    initial begin
        reset  = 1'b1;
        push_a = 1'b1;
        pop_a  = 1'b0;
        push_b = 1'b0;
        pop_b  = 1'b0;
        wdata_a = '0;
        wdata_b = '0;
        #3;
        check("wr_en_masked_by_reset", wr_en_a, 0);
        cycle();
        push_a = 1'b0;
        reset  = 1'b0;
        check("rst_count", count_a, 0);
        check("rst_empty", empty_a, 1);
        check("rst_full", full_a, 0);
        check("rst_wr_addr", wr_addr_a, 0);
        check("rst_rd_addr", rd_addr_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_unf", unf_a, 0);
        check("rst_wr_en", wr_en_a, 0);
        check("rst_rd_en", rd_en_a, 0);

        // Fill with 16 single-word pushes.
        for (int i = 0; i < 16; i++) begin
            push_a  = 1'b1;
            wdata_a = 16'h1000 + 16'(i);
            #2;
            check("fill_wr_en", wr_en_a, 1);
            check("fill_wr_addr", wr_addr_a, 64'(i));
            cycle();
            check("fill_count", count_a, 64'(i + 1));
            check("fill_empty", empty_a, (i + 1 < 4) ? 1 : 0);
            check("fill_full", full_a, (i == 15) ? 1 : 0);
        end
        check("fill_wr_wrap", wr_addr_a, 0);
        #2;
        check("push_full_wr_en", wr_en_a, 0);
        cycle();
        push_a = 1'b0;
        check("overflow_set", ovf_a, 1);
        check("overflow_count", count_a, 16);
        check("overflow_wr_addr", wr_addr_a, 0);

        // Drain in four 64-bit beats.
        for (int j = 0; j < 4; j++) begin
            pop_a = 1'b1;
            for (int k = 0; k < 4; k++) exp_beat[16*k +: 16] = 16'h1000 + 16'(4 * j + k);
            #2;
            check("drain_rd_en", rd_en_a, 1);
            check("drain_rd_addr", rd_addr_a, 64'(4 * j));
            check("drain_data", rdata_a, exp_beat);
            cycle();
            check("drain_count", count_a, 64'(12 - 4 * j));
        end
        check("drain_rd_wrap", rd_addr_a, 0);
        check("drain_empty", empty_a, 1);
        #2;
        check("pop_empty_rd_en", rd_en_a, 0);
        cycle();
        pop_a = 1'b0;
        check("underflow_set", unf_a, 1);
        check("underflow_count", count_a, 0);
        check("overflow_sticky", ovf_a, 1);

        // Simultaneous push and pop.
        do_reset();
        push_a = 1'b1;
        repeat (5) cycle();
        check("sim_pre_count", count_a, 5);
        pop_a = 1'b1;
        #2;
        check("sim_wr_en", wr_en_a, 1);
        check("sim_rd_en", rd_en_a, 1);
        cycle();
        check("sim_count_a", count_a, 2);
        #2;
        check("sim_rd_rejected", rd_en_a, 0);
        check("sim_wr_accepted", wr_en_a, 1);
        cycle();
        push_a = 1'b0;
        pop_a  = 1'b0;
        check("sim_count_b", count_a, 3);
        check("sim_underflow", unf_a, 1);

        // No write-to-read bypass; pop only once a full beat is present.
        do_reset();
        push_a = 1'b1;
        cycle();
        push_a = 1'b0;
        pop_a  = 1'b1;
        #2;
        check("partial_rd_en", rd_en_a, 0);
        cycle();
        pop_a = 1'b0;
        check("partial_count", count_a, 1);
        push_a = 1'b1;
        repeat (3) cycle();
        push_a = 1'b0;
        check("beat_count", count_a, 4);
        check("beat_empty", empty_a, 0);
        pop_a = 1'b1;
        #2;
        check("beat_rd_en", rd_en_a, 1);
        cycle();
        pop_a = 1'b0;
        check("beat_count_after", count_a, 0);

        // Reset mid-stream with count 9 and overflow set.
        do_reset();
        push_a = 1'b1;
        repeat (17) cycle();
        push_a = 1'b0;
        pop_a  = 1'b1;
        repeat (2) cycle();
        pop_a  = 1'b0;
        push_a = 1'b1;
        cycle();
        push_a = 1'b0;
        check("mid_pre_count", count_a, 9);
        check("mid_pre_ovf", ovf_a, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_count", count_a, 0);
        check("mid_wr_addr", wr_addr_a, 0);
        check("mid_rd_addr", rd_addr_a, 0);
        check("mid_empty", empty_a, 1);
        check("mid_full", full_a, 0);
        check("mid_ovf", ovf_a, 0);

        // Swapped widths: 64-bit write, 16-bit read.
        push_b  = 1'b1;
        wdata_b = 64'h4444_3333_2222_1111;
        #2;
        check("b_wr_en", wr_en_b, 1);
        cycle();
        check("b_count_one", count_b, 4);
        check("b_empty", empty_b, 0);
        check("b_wr_addr", wr_addr_b, 4);
        wdata_b = 64'h8888_7777_6666_5555;
        repeat (2) cycle();
        check("b_count_12", count_b, 12);
        check("b_full_12", full_b, 0);
        cycle();
        push_b = 1'b0;
        check("b_count_16", count_b, 16);
        check("b_full_16", full_b, 1);
        for (int k = 0; k < 4; k++) begin
            pop_b = 1'b1;
            #2;
            check("b_rd_en", rd_en_b, 1);
            check("b_lane", rdata_b, 64'(16'h1111 * 16'(k + 1)));
            cycle();
        end
        pop_b = 1'b0;
        check("b_count_after", count_b, 12);
        check("b_rd_addr", rd_addr_b, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
